// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Merges N_SRC execution-unit result streams into the single
//                register-file write port, one write per cycle, and keeps a
//                pending-write scoreboard that decode queries for RAW hazards.
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_arbiter #(
  parameter int N_SRC     = 3,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_SRC-1:0]      src_valid,
  output logic [N_SRC-1:0]      src_ready,
  input  logic [5*N_SRC-1:0]    src_rd,
  input  logic [32*N_SRC-1:0]   src_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic [4:0]            query_rs1,
  input  logic [4:0]            query_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  reg_wren,
  output logic [4:0]            write_address,
  output logic [31:0]           write_data
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_next;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_valid;
  logic             handshake;
  logic [4:0]       grant_rd;
  logic [31:0]      grant_data;
  logic [31:0]      busy;
  logic [31:0]      busy_next;

  // Pick one valid source: scan from rr_ptr (round robin) or from 0 (fixed priority)
  always_comb begin : arbitration
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (RR_ENABLE) idx = (int'(rr_ptr) + k) % N_SRC;
      else           idx = k;
      if (!grant_valid && src_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
    // Ready is suppressed during reset so no source believes it was accepted
    handshake  = grant_valid & reset_n;
    src_ready  = handshake ? (N_SRC'(1) << grant_idx) : '0;
    grant_rd   = src_rd[int'(grant_idx)*5 +: 5];
    grant_data = src_data[int'(grant_idx)*32 +: 32];
    rr_next    = (grant_idx == PTR_W'(N_SRC-1)) ? '0 : grant_idx + 1'b1;
  end

  // Scoreboard next state: clear the landing write first so a same-edge issue wins
  always_comb begin
    busy_next = busy;
    if (reg_wren) busy_next[write_address] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Write stage, round-robin pointer and scoreboard registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_wren      <= 1'b0;
      write_address <= 5'd0;
      write_data    <= 32'd0;
      rr_ptr        <= '0;
      busy          <= 32'd0;
    end else begin
      reg_wren <= handshake && (grant_rd != 5'd0);
      if (handshake) begin
        write_address <= grant_rd;
        write_data    <= grant_data;
        rr_ptr        <= rr_next;
      end
      busy <= busy_next;
    end
  end

  // Hazard query: plain lookup, no bypass from the landing write
  always_comb begin
    rs1_busy = busy[query_rs1];
    rs2_busy = busy[query_rs2];
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Self-checking bench for writeback_arbiter with a behavioural
//                model; a second fixed-priority instance shares the inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N-1:0]    src_ready_fp;
  logic [5*N-1:0]  src_rd;
  logic [32*N-1:0] src_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      query_rs1;
  logic [4:0]      query_rs2;
  logic            rs1_busy, rs2_busy, reg_wren;
  logic [4:0]      write_address;
  logic [31:0]     write_data;
  logic            rs1_busy_fp, rs2_busy_fp, reg_wren_fp;
  logic [4:0]      write_address_fp;
  logic [31:0]     write_data_fp;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_rr;
  bit          m_busy [32];
  bit          m_wren;
  bit [4:0]    m_addr;
  bit [31:0]   m_data;
  // Source-side state (each source holds its result until accepted)
  bit          sv   [N];
  bit [4:0]    srd  [N];
  bit [31:0]   sdat [N];

  always #5 clk = ~clk;

  writeback_arbiter #(.N_SRC(N), .RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .query_rs1(query_rs1), .query_rs2(query_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reg_wren(reg_wren), .write_address(write_address), .write_data(write_data)
  );

  writeback_arbiter #(.N_SRC(N), .RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_ready(src_ready_fp),
    .src_rd(src_rd), .src_data(src_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .query_rs1(query_rs1), .query_rs2(query_rs2), .rs1_busy(rs1_busy_fp), .rs2_busy(rs2_busy_fp),
    .reg_wren(reg_wren_fp), .write_address(write_address_fp), .write_data(write_data_fp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      src_valid[i]         = sv[i];
      src_rd[5*i +: 5]     = srd[i];
      src_data[32*i +: 32] = sdat[i];
    end
  endtask

  // Round robin: first valid source at or after the pointer, wrapping
  function automatic int exp_grant();
    for (int k = 0; k < N; k++)
      if (sv[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic int exp_grant_fp();
    for (int k = 0; k < N; k++)
      if (sv[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int g);
    return (g < 0) ? 32'd0 : (32'd1 << g);
  endfunction

  task automatic model_reset();
    m_rr = 0; m_wren = 0; m_addr = 0; m_data = 0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  task automatic check_comb();
    check("src_ready",    src_ready,    onehot(exp_grant()));
    check("src_ready_fp", src_ready_fp, onehot(exp_grant_fp()));
    check("rs1_busy", rs1_busy, 32'(m_busy[query_rs1]));
    check("rs2_busy", rs2_busy, 32'(m_busy[query_rs2]));
  endtask

  task automatic check_regs();
    check("reg_wren",      reg_wren,      32'(m_wren));
    check("write_address", write_address, 32'(m_addr));
    check("write_data",    write_data,    m_data);
  endtask

  // One clock: drive, check combinational outputs, advance model, check registers
  task automatic cycle(output int g);
    drive_src();
    #1;
    check_comb();
    g = exp_grant();
    if (m_wren) m_busy[m_addr] = 0;
    if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1;
    if (g >= 0) begin
      m_wren = (srd[g] != 5'd0);
      m_addr = srd[g];
      m_data = sdat[g];
      m_rr   = (g + 1) % N;
      sv[g]  = 0;
    end else begin
      m_wren = 0;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin sv[i] = 0; srd[i] = 0; sdat[i] = 0; end
    issue_valid = 0; issue_rd = 0; query_rs1 = 0; query_rs2 = 0;
    drive_src();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_reg_wren", reg_wren, 32'd0);
    check("rst_addr", write_address, 32'd0);
    check("rst_data", write_data, 32'd0);
    model_reset();
    clear_inputs();
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int g;
  logic [2:0] rr_seq [6];

  initial begin
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;
    clear_inputs();
    // Reset with all sources asserting valid
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin sv[i] = 1; srd[i] = 5'(i + 1); sdat[i] = 32'(i); end
    drive_src();
    #2;
    check("rst_ready", src_ready, 32'd0);
    check("rst_ready_fp", src_ready_fp, 32'd0);
    check("rst_wren", reg_wren, 32'd0);
    for (int r = 0; r < 32; r += 7) begin
      query_rs1 = 5'(r);
      #1;
      check("rst_busy", rs1_busy, 32'd0);
    end
    do_reset();

    // Single write from source 1
    sv[1] = 1; srd[1] = 5'd5; sdat[1] = 32'hDEADBEEF;
    cycle(g);
    check("t2_wren", reg_wren, 32'd1);
    check("t2_addr", write_address, 32'd5);
    check("t2_data", write_data, 32'hDEADBEEF);
    cycle(g);
    check("t2_wren_off", reg_wren, 32'd0);

    // Round robin from reset, all sources valid
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin sv[i] = 1; srd[i] = 5'(8 + i); sdat[i] = $urandom; end
      drive_src();
      #1;
      check("t3_rr", src_ready, 32'(rr_seq[k]));
      check("t3_fp", src_ready_fp, 32'd1);
      cycle(g);
    end
    clear_inputs();

    // x0 destination is consumed but never written or tracked
    sv[0] = 1; srd[0] = 5'd0; sdat[0] = 32'h1234;
    issue_valid = 1; issue_rd = 5'd0; query_rs1 = 5'd0;
    cycle(g);
    check("t4_wren", reg_wren, 32'd0);
    check("t4_busy0", rs1_busy, 32'd0);
    issue_valid = 0;
    cycle(g);
    check("t4_busy0b", rs1_busy, 32'd0);

    // Scoreboard timing for rd=10
    issue_valid = 1; issue_rd = 5'd10; query_rs1 = 5'd10;
    cycle(g);
    issue_valid = 0;
    check("t5_busy_c1", rs1_busy, 32'd1);
    cycle(g);
    cycle(g);
    sv[2] = 1; srd[2] = 5'd10; sdat[2] = 32'hA5A5_0010;
    cycle(g);
    check("t5_wren_c4", reg_wren, 32'd1);
    check("t5_busy_c4", rs1_busy, 32'd1);
    cycle(g);
    check("t5_busy_c5", rs1_busy, 32'd0);

    // Set/clear collision on r7: set wins
    issue_valid = 1; issue_rd = 5'd7; query_rs1 = 5'd7;
    cycle(g);
    issue_valid = 0;
    sv[0] = 1; srd[0] = 5'd7; sdat[0] = 32'h7777;
    cycle(g);
    check("t6_wren", reg_wren, 32'd1);
    issue_valid = 1; issue_rd = 5'd7;
    cycle(g);
    issue_valid = 0;
    check("t6_busy_set", rs1_busy, 32'd1);
    cycle(g);
    check("t6_busy_hold", rs1_busy, 32'd1);

    // Asynchronous reset pulse with a write pending
    sv[1] = 1; srd[1] = 5'd9; sdat[1] = 32'hCAFE_0009;
    cycle(g);
    check("t6_pre_wren", reg_wren, 32'd1);
    do_reset();
    query_rs1 = 5'd7;
    #1;
    check("t6_post_busy", rs1_busy, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!sv[i] && ($urandom_range(0, 1) == 1)) begin
          sv[i] = 1; srd[i] = 5'($urandom_range(0, 15)); sdat[i] = $urandom;
        end
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 15));
      query_rs1   = 5'($urandom_range(0, 15));
      query_rs2   = 5'($urandom_range(0, 15));
      cycle(g);
      if (c == 200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
